// File: rtl/ciclo_bus_rtc_if.sv
// Request/bus bundle between the read/write request FSM, the ciclo_bus_rtc engine and the RTC AD pads.
// master = requester and pad side, slave = bus-cycle engine.
interface ciclo_bus_rtc_if;
    logic       activa;
    logic       w;
    logic [7:0] dir;
    logic [7:0] dato_in;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;
    logic [7:0] dato_leido;
    logic       fin;
    logic       ocupado;
    logic       err_lectura;

    modport master (
        output activa, w, dir, dato_in, ad_in,
        input  ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, dato_leido, fin, ocupado, err_lectura
    );

    modport slave (
        input  activa, w, dir, dato_in, ad_in,
        output ad_out, ad_oe, cs_n, rd_n, wr_n, a_d, dato_leido, fin, ocupado, err_lectura
    );
endinterface

// File: rtl/ciclo_bus_rtc.sv
// RTC bus-cycle engine: runs one multiplexed address/data cycle per accepted request and pulses fin.
// Optional feature macro CICLO_BUS_RTC_DOBLE_MUESTRA_EN adds a mid-DAT read sample and err_lectura.
module ciclo_bus_rtc #(
    parameter int PULSE_CYC = 10,
    parameter int GAP_CYC   = 4
) (
    input  logic             clk,
    input  logic             reset,
    ciclo_bus_rtc_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADR     = 3'd1,
        ADR_GAP = 3'd2,
        DAT     = 3'd3,
        DAT_GAP = 3'd4,
        FIN     = 3'd5,
        ESPERA  = 3'd6
    } state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);
    localparam logic [7:0] MID_CNT  = 8'(PULSE_CYC / 2);

    state_t     state_r;
    state_t     next_state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       fase_fin_s;
    logic       accept_s;

    logic       w_r;
    logic [7:0] dir_r;
    logic [7:0] dato_r;
    logic       w_n_s;
    logic [7:0] dir_n_s;
    logic [7:0] dato_n_s;
    logic [7:0] dato_leido_r;
    logic       captura_s;

    logic       cs_n_s, rd_n_s, wr_n_s, a_d_s, ad_oe_s, fin_s, ocupado_s;
    logic [7:0] ad_out_s;
    logic       cs_n_r, rd_n_r, wr_n_r, a_d_r, ad_oe_r, fin_r, ocupado_r;
    logic [7:0] ad_out_r;

    assign fase_fin_s = (cnt_r == 8'd0);
    assign accept_s   = (state_r == IDLE) && bus.activa;
    assign captura_s  = (state_r == DAT) && fase_fin_s && !w_r;

    // On the accept edge the request fields are not latched yet, so outputs decode from the live inputs.
    assign w_n_s    = accept_s ? bus.w       : w_r;
    assign dir_n_s  = accept_s ? bus.dir     : dir_r;
    assign dato_n_s = accept_s ? bus.dato_in : dato_r;

    // State register and phase counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.activa) next_state_s = ADR;
                else            next_state_s = IDLE;
            end
            ADR: begin
                if (fase_fin_s) next_state_s = ADR_GAP;
                else            next_state_s = ADR;
            end
            ADR_GAP: begin
                if (fase_fin_s) next_state_s = DAT;
                else            next_state_s = ADR_GAP;
            end
            DAT: begin
                if (fase_fin_s) next_state_s = DAT_GAP;
                else            next_state_s = DAT;
            end
            DAT_GAP: begin
                if (fase_fin_s) next_state_s = FIN;
                else            next_state_s = DAT_GAP;
            end
            FIN: begin
                if (bus.activa) next_state_s = ESPERA;
                else            next_state_s = IDLE;
            end
            ESPERA: begin
                if (bus.activa) next_state_s = ESPERA;
                else            next_state_s = IDLE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Phase counter: reload on every phase entry, count down to zero inside a phase.
    always_comb begin
        cnt_next_s = 8'd0;
        if (next_state_s != state_r) begin
            case (next_state_s)
                ADR, DAT:         cnt_next_s = PULSE_LD;
                ADR_GAP, DAT_GAP: cnt_next_s = GAP_LD;
                default:          cnt_next_s = 8'd0;
            endcase
        end else if (cnt_r != 8'd0) begin
            cnt_next_s = cnt_r - 8'd1;
        end else begin
            cnt_next_s = 8'd0;
        end
    end

    // Output decode from the state being entered, so the registered outputs line up with that state.
    always_comb begin
        cs_n_s    = 1'b1;
        rd_n_s    = 1'b1;
        wr_n_s    = 1'b1;
        a_d_s     = 1'b1;
        ad_oe_s   = 1'b0;
        ad_out_s  = 8'h00;
        fin_s     = 1'b0;
        ocupado_s = (next_state_s != IDLE);
        case (next_state_s)
            ADR: begin
                cs_n_s   = 1'b0;
                wr_n_s   = 1'b0;
                a_d_s    = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = dir_n_s;
            end
            ADR_GAP: begin
                a_d_s = 1'b0;
            end
            DAT: begin
                cs_n_s = 1'b0;
                if (w_n_s) begin
                    wr_n_s   = 1'b0;
                    ad_oe_s  = 1'b1;
                    ad_out_s = dato_n_s;
                end else begin
                    rd_n_s   = 1'b0;
                end
            end
            FIN: begin
                fin_s = 1'b1;
            end
            default: begin
                fin_s = 1'b0;
            end
        endcase
    end

    // Registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cs_n_r    <= 1'b1;
            rd_n_r    <= 1'b1;
            wr_n_r    <= 1'b1;
            a_d_r     <= 1'b1;
            ad_oe_r   <= 1'b0;
            ad_out_r  <= 8'h00;
            fin_r     <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            cs_n_r    <= cs_n_s;
            rd_n_r    <= rd_n_s;
            wr_n_r    <= wr_n_s;
            a_d_r     <= a_d_s;
            ad_oe_r   <= ad_oe_s;
            ad_out_r  <= ad_out_s;
            fin_r     <= fin_s;
            ocupado_r <= ocupado_s;
        end
    end

    // Request latch at accept and final read-data capture at the end of DAT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w_r          <= 1'b0;
            dir_r        <= 8'h00;
            dato_r       <= 8'h00;
            dato_leido_r <= 8'h00;
        end else begin
            if (accept_s) begin
                w_r    <= bus.w;
                dir_r  <= bus.dir;
                dato_r <= bus.dato_in;
            end
            if (captura_s) begin
                dato_leido_r <= bus.ad_in;
            end
        end
    end

`ifdef CICLO_BUS_RTC_DOBLE_MUESTRA_EN
    logic [7:0] mid_r;
    logic       err_r;

    // Mid-DAT sample; by FIN the final sample already sits in dato_leido_r since DAT_GAP lasts at least one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mid_r <= 8'h00;
            err_r <= 1'b0;
        end else begin
            if ((state_r == DAT) && (cnt_r == MID_CNT) && !w_r) begin
                mid_r <= bus.ad_in;
            end
            err_r <= (next_state_s == FIN) && !w_r && (mid_r != dato_leido_r);
        end
    end

    assign bus.err_lectura = err_r;
`else
    assign bus.err_lectura = 1'b0;
`endif

    assign bus.cs_n       = cs_n_r;
    assign bus.rd_n       = rd_n_r;
    assign bus.wr_n       = wr_n_r;
    assign bus.a_d        = a_d_r;
    assign bus.ad_oe      = ad_oe_r;
    assign bus.ad_out     = ad_out_r;
    assign bus.fin        = fin_r;
    assign bus.ocupado    = ocupado_r;
    assign bus.dato_leido = dato_leido_r;

endmodule

// File: tb/tb_ciclo_bus_rtc.sv
// Directed bench for ciclo_bus_rtc: default instance (10/4) plus a 1/1 timing corner instance.
module tb_ciclo_bus_rtc;

`ifdef CICLO_BUS_RTC_DOBLE_MUESTRA_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ciclo_bus_rtc_if bus ();
    ciclo_bus_rtc_if bus2 ();

    ciclo_bus_rtc dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ciclo_bus_rtc #(.PULSE_CYC(1), .GAP_CYC(1)) dut_min (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int         s_adr, s_dat_w, s_dat_r, s_rd_low, s_wr_low, s_oe_rd, s_fin, s_fin_at;
    logic [7:0] s_dato_fin;
    logic       s_err_fin, s_ocup1, s_ocup_after, s_ocup_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic wv, input logic [7:0] d, input logic [7:0] v);
        bus.w       = wv;
        bus.dir     = d;
        bus.dato_in = v;
        bus.activa  = 1'b1;
    endtask

    // Cycle i is the cycle after the i-th edge following the accept setup (i = 1 is ADR's first cycle).
    task automatic scan(input int ncyc, input bit drop, input logic [7:0] e_dir, input logic [7:0] e_dat,
                        input logic [7:0] mid_v, input logic [7:0] fin_v);
        s_adr = 0; s_dat_w = 0; s_dat_r = 0; s_rd_low = 0; s_wr_low = 0; s_oe_rd = 0;
        s_fin = 0; s_fin_at = 0; s_dato_fin = 8'h00; s_err_fin = 1'b0;
        s_ocup1 = 1'b0; s_ocup_after = 1'b1; s_ocup_last = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            tick();
            if (i >= 15 && i <= 19)      bus.ad_in = mid_v;
            else if (i >= 20 && i <= 24) bus.ad_in = fin_v;
            else                         bus.ad_in = 8'hEE;
            if (i == 2) begin
                bus.dir     = ~e_dir;
                bus.dato_in = ~e_dat;
            end
            if (!bus.cs_n && !bus.a_d && !bus.wr_n && bus.rd_n && bus.ad_oe && bus.ad_out == e_dir) s_adr++;
            if (!bus.cs_n && bus.a_d && !bus.wr_n && bus.rd_n && bus.ad_oe && bus.ad_out == e_dat) s_dat_w++;
            if (!bus.cs_n && bus.a_d && !bus.rd_n && bus.wr_n && !bus.ad_oe) s_dat_r++;
            if (!bus.rd_n) s_rd_low++;
            if (!bus.wr_n) s_wr_low++;
            if (!bus.rd_n && bus.ad_oe) s_oe_rd++;
            if (i == 1) s_ocup1 = bus.ocupado;
            if (s_fin_at != 0 && i == s_fin_at + 1) s_ocup_after = bus.ocupado;
            s_ocup_last = bus.ocupado;
            if (bus.fin) begin
                s_fin++;
                if (s_fin_at == 0) s_fin_at = i;
                s_dato_fin = bus.dato_leido;
                s_err_fin  = bus.err_lectura;
                if (drop) bus.activa = 1'b0;
            end
        end
    endtask

    initial begin
        logic [4:0] csv;
        int         fin2_at;
        int         fin2_cnt;
        logic [7:0] ad2_c1, ad2_c3;

        reset = 1'b0;
        bus.activa = 1'b0; bus.w = 1'b0; bus.dir = 8'h00; bus.dato_in = 8'h00; bus.ad_in = 8'h00;
        bus2.activa = 1'b0; bus2.w = 1'b0; bus2.dir = 8'h00; bus2.dato_in = 8'h00; bus2.ad_in = 8'h00;
        tick(); tick(); tick();

        chk("reset_outs", {bus.cs_n, bus.rd_n, bus.wr_n, bus.a_d, bus.ad_oe, bus.fin, bus.ocupado,
                           bus.err_lectura, bus.ad_out, bus.dato_leido}, 32'h00F0_0000);
        chk("reset_outs_min", {bus2.cs_n, bus2.rd_n, bus2.wr_n, bus2.a_d, bus2.ad_oe, bus2.fin,
                               bus2.ocupado, bus2.err_lectura, bus2.ad_out, bus2.dato_leido}, 32'h00F0_0000);
        reset = 1'b1;
        tick();

        // write 0x59 to register 0x21
        start(1'b1, 8'h21, 8'h59);
        scan(35, 1'b1, 8'h21, 8'h59, 8'hEE, 8'hEE);
        chk("wr_adr_cycles", s_adr, 32'd10);
        chk("wr_dat_cycles", s_dat_w, 32'd10);
        chk("wr_fin_at", s_fin_at, 32'd29);
        chk("wr_fin_count", s_fin, 32'd1);
        chk("wr_rd_low", s_rd_low, 32'd0);
        chk("wr_ocup_rise", s_ocup1, 32'd1);
        chk("wr_ocup_fall", s_ocup_after, 32'd0);
        chk("wr_dato_leido", bus.dato_leido, 32'h00);

        // read of register 0x22 returning 0x47
        start(1'b0, 8'h22, 8'h00);
        scan(35, 1'b1, 8'h22, 8'h00, 8'h47, 8'h47);
        chk("rd_adr_cycles", s_adr, 32'd10);
        chk("rd_dat_cycles", s_dat_r, 32'd10);
        chk("rd_oe_while_rd", s_oe_rd, 32'd0);
        chk("rd_wr_low_adr_only", s_wr_low, 32'd10);
        chk("rd_fin_at", s_fin_at, 32'd29);
        chk("rd_dato_at_fin", s_dato_fin, 32'h47);
        chk("rd_err_stable", s_err_fin, 32'd0);

        // mid-point 0x10, final 0x11
        start(1'b0, 8'h23, 8'h00);
        scan(35, 1'b1, 8'h23, 8'h00, 8'h10, 8'h11);
        chk("dbl_dato_final", s_dato_fin, 32'h11);
        chk("dbl_err_at_fin", s_err_fin, {31'd0, EXP_ERR});
        chk("dbl_err_after", bus.err_lectura, 32'd0);

        // request held high long after fin
        start(1'b1, 8'h30, 8'h31);
        scan(60, 1'b0, 8'h30, 8'h31, 8'hEE, 8'hEE);
        chk("hold_fin_count", s_fin, 32'd1);
        chk("hold_ocup_espera", s_ocup_last, 32'd1);
        chk("hold_wr_keeps_dato", bus.dato_leido, 32'h11);
        bus.activa = 1'b0;
        tick();
        chk("hold_release_idle", bus.ocupado, 32'd0);
        start(1'b1, 8'h32, 8'h33);
        scan(35, 1'b1, 8'h32, 8'h33, 8'hEE, 8'hEE);
        chk("hold_restart_fin_at", s_fin_at, 32'd29);
        chk("hold_restart_dat", s_dat_w, 32'd10);

        // reset during DAT of a write
        start(1'b1, 8'h40, 8'h41);
        scan(17, 1'b0, 8'h40, 8'h41, 8'hEE, 8'hEE);
        chk("mid_in_dat", {bus.cs_n, bus.wr_n, bus.a_d}, 32'b001);
        reset = 1'b0;
        tick();
        chk("mid_rst_outs", {bus.cs_n, bus.wr_n, bus.ad_oe, bus.ocupado, bus.fin}, 32'b11000);
        reset = 1'b1;
        bus.activa = 1'b0;
        scan(30, 1'b0, 8'h40, 8'h41, 8'hEE, 8'hEE);
        chk("mid_rst_no_fin", s_fin, 32'd0);
        start(1'b0, 8'h42, 8'h00);
        scan(35, 1'b1, 8'h42, 8'h00, 8'h3C, 8'h3C);
        chk("post_rst_rd_fin_at", s_fin_at, 32'd29);
        chk("post_rst_rd_dato", s_dato_fin, 32'h3C);

        // PULSE_CYC=1, GAP_CYC=1 corner
        bus2.w = 1'b1; bus2.dir = 8'hA5; bus2.dato_in = 8'h5A; bus2.activa = 1'b1;
        csv = 5'b00000; fin2_at = 0; fin2_cnt = 0; ad2_c1 = 8'h00; ad2_c3 = 8'h00;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i <= 5) csv[i-1] = bus2.cs_n;
            if (i == 1) ad2_c1 = bus2.ad_out;
            if (i == 3) ad2_c3 = bus2.ad_out;
            if (bus2.fin) begin
                fin2_cnt++;
                if (fin2_at == 0) fin2_at = i;
                bus2.activa = 1'b0;
            end
        end
        chk("min_fin_at", fin2_at, 32'd5);
        chk("min_fin_count", fin2_cnt, 32'd1);
        chk("min_cs_pattern", csv, 32'b11010);
        chk("min_adr_out", ad2_c1, 32'hA5);
        chk("min_dat_out", ad2_c3, 32'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
